// File: rtl/fetch_target_queue_if.sv
// Bundle of BPU enqueue, IFU fetch, backend commit/read/flush and status signals
// for the fetch target queue. Suffixes _i/_o are relative to the queue itself.
interface fetch_target_queue_if #(
  parameter int PLEN            = 32,
  parameter int INSTR_PER_FETCH = 4,
  parameter int DEPTH           = 8,
  parameter int EPOCH_W         = 3
);
  localparam int SLOT_W = $clog2(INSTR_PER_FETCH);
  localparam int ID_W   = $clog2(DEPTH);

  // Enqueue and fetch are strict valid/ready: a transfer happens on the rising
  // edge where both are high; the producer holds fields stable until then.
  logic              enq_valid_i;
  logic              enq_ready_o;
  logic [PLEN-1:0]   enq_pc_i;
  logic [PLEN-1:0]   enq_npc_i;
  logic              enq_pred_slot_valid_i;
  logic [SLOT_W-1:0] enq_pred_slot_idx_i;
  logic [PLEN-1:0]   enq_pred_target_i;

  logic              fetch_valid_o;
  logic              fetch_ready_i;
  logic [PLEN-1:0]   fetch_pc_o;
  logic [PLEN-1:0]   fetch_npc_o;
  logic [PLEN-1:0]   fetch_pred_target_o;
  logic              fetch_pred_slot_valid_o;
  logic [SLOT_W-1:0] fetch_pred_slot_idx_o;
  logic [ID_W-1:0]   fetch_ftq_id_o;
  logic [EPOCH_W-1:0] fetch_epoch_o;

  logic              commit_valid_i;
  logic [ID_W-1:0]   commit_ftq_id_i;
  logic [ID_W-1:0]   rd_ftq_id_i;
  logic [PLEN-1:0]   rd_pc_o;
  logic [PLEN-1:0]   rd_npc_o;
  logic              flush_i;

  logic [ID_W:0]     count_o;
  logic              full_o;
  logic              empty_o;

  modport master (
    output enq_valid_i, enq_pc_i, enq_npc_i, enq_pred_slot_valid_i,
           enq_pred_slot_idx_i, enq_pred_target_i, fetch_ready_i,
           commit_valid_i, commit_ftq_id_i, rd_ftq_id_i, flush_i,
    input  enq_ready_o, fetch_valid_o, fetch_pc_o, fetch_npc_o,
           fetch_pred_target_o, fetch_pred_slot_valid_o, fetch_pred_slot_idx_o,
           fetch_ftq_id_o, fetch_epoch_o, rd_pc_o, rd_npc_o,
           count_o, full_o, empty_o
  );

  modport slave (
    input  enq_valid_i, enq_pc_i, enq_npc_i, enq_pred_slot_valid_i,
           enq_pred_slot_idx_i, enq_pred_target_i, fetch_ready_i,
           commit_valid_i, commit_ftq_id_i, rd_ftq_id_i, flush_i,
    output enq_ready_o, fetch_valid_o, fetch_pc_o, fetch_npc_o,
           fetch_pred_target_o, fetch_pred_slot_valid_o, fetch_pred_slot_idx_o,
           fetch_ftq_id_o, fetch_epoch_o, rd_pc_o, rd_npc_o,
           count_o, full_o, empty_o
  );
endinterface

// File: rtl/fetch_target_queue.sv
// In-order queue between BPU and IFU with enqueue, fetch and commit pointers,
// per-group ftq_id, fetch epoch and a random-access PC/NPC read port.
module fetch_target_queue #(
  parameter int PLEN            = 32,
  parameter int INSTR_PER_FETCH = 4,
  parameter int DEPTH           = 8,
  parameter int EPOCH_W         = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  fetch_target_queue_if.slave bus
);
  localparam int SLOT_W = $clog2(INSTR_PER_FETCH);
  localparam int ID_W   = $clog2(DEPTH);
  localparam logic [ID_W:0] PTR_ONE = (ID_W+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ID_W:0]      enq_ptr, fetch_ptr, cmt_ptr;
  logic [EPOCH_W-1:0] epoch;

  logic [PLEN-1:0]   pc_q     [DEPTH];
  logic [PLEN-1:0]   npc_q    [DEPTH];
  logic [PLEN-1:0]   tgt_q    [DEPTH];
  logic              slot_v_q [DEPTH];
  logic [SLOT_W-1:0] slot_i_q [DEPTH];

  logic [ID_W:0]   count, unfetched, fetched;
  logic [ID_W-1:0] commit_dist;
  logic            full, enq_ready, fetch_valid;
  logic            enq_fire, fetch_fire, commit_ok;
  logic [ID_W-1:0] enq_idx, fetch_idx;

  assign count       = enq_ptr - cmt_ptr;
  assign unfetched   = enq_ptr - fetch_ptr;
  assign fetched     = fetch_ptr - cmt_ptr;
  assign full        = (count == (ID_W+1)'(DEPTH));
  assign enq_ready   = !full && !bus.flush_i;
  assign fetch_valid = (unfetched != '0) && !bus.flush_i;
  assign enq_fire    = bus.enq_valid_i && enq_ready;
  assign fetch_fire  = fetch_valid && bus.fetch_ready_i;
  assign enq_idx     = enq_ptr[ID_W-1:0];
  assign fetch_idx   = fetch_ptr[ID_W-1:0];

  // A commit may only retire groups the IFU has already taken.
  assign commit_dist = bus.commit_ftq_id_i - cmt_ptr[ID_W-1:0];
  assign commit_ok   = bus.commit_valid_i && ({1'b0, commit_dist} < fetched);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enq_ptr   <= '0;
      fetch_ptr <= '0;
      cmt_ptr   <= '0;
      epoch     <= '0;
    end else if (bus.flush_i) begin
      fetch_ptr <= enq_ptr;
      cmt_ptr   <= enq_ptr;
      epoch     <= epoch + EPOCH_W'(1);
    end else begin
      if (enq_fire)   enq_ptr   <= enq_ptr + PTR_ONE;
      if (fetch_fire) fetch_ptr <= fetch_ptr + PTR_ONE;
      if (commit_ok)  cmt_ptr   <= cmt_ptr + {1'b0, commit_dist} + PTR_ONE;
    end
  end

  // Payload storage is never reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (enq_fire && !rst_i) begin
      pc_q[enq_idx]     <= bus.enq_pc_i;
      npc_q[enq_idx]    <= bus.enq_npc_i;
      tgt_q[enq_idx]    <= bus.enq_pred_target_i;
      slot_v_q[enq_idx] <= bus.enq_pred_slot_valid_i;
      slot_i_q[enq_idx] <= bus.enq_pred_slot_idx_i;
    end
  end

  assign bus.enq_ready_o             = enq_ready;
  assign bus.fetch_valid_o           = fetch_valid;
  assign bus.fetch_pc_o              = pc_q[fetch_idx];
  assign bus.fetch_npc_o             = npc_q[fetch_idx];
  assign bus.fetch_pred_target_o     = tgt_q[fetch_idx];
  assign bus.fetch_pred_slot_valid_o = slot_v_q[fetch_idx];
  assign bus.fetch_pred_slot_idx_o   = slot_i_q[fetch_idx];
  assign bus.fetch_ftq_id_o          = fetch_idx;
  assign bus.fetch_epoch_o           = epoch;
  assign bus.rd_pc_o                 = pc_q[bus.rd_ftq_id_i];
  assign bus.rd_npc_o                = npc_q[bus.rd_ftq_id_i];
  assign bus.count_o                 = count;
  assign bus.full_o                  = full;
  assign bus.empty_o                 = (count == '0);
endmodule

// File: tb/tb_fetch_target_queue.sv
// Randomised and directed bench for fetch_target_queue; a queue-of-groups model
// predicts every output and is compared on each falling edge.
module tb_fetch_target_queue;
  localparam int PLEN = 32;
  localparam int IPF  = 4;
  localparam int D    = 8;
  localparam int EW_E = 3;
  localparam int EW   = 3*PLEN + 1 + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  fetch_target_queue_if #(.PLEN(PLEN), .INSTR_PER_FETCH(IPF), .DEPTH(D), .EPOCH_W(EW_E)) bus ();

  fetch_target_queue #(.PLEN(PLEN), .INSTR_PER_FETCH(IPF), .DEPTH(D), .EPOCH_W(EW_E)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds in-flight groups oldest first; the first n_fetched are with the IFU.
  logic [EW-1:0]   exp_q[$];
  int              n_fetched = 0;
  int              enq_total = 0;
  int              m_epoch = 0;
  bit              model_ok = 0;
  bit              written[D];
  logic [PLEN-1:0] m_rd_pc[D];
  logic [PLEN-1:0] m_rd_npc[D];

  always @(negedge clk) begin : compare
    logic [EW-1:0] e;
    int head_id, d, rid;
    bit x_enq_ready, x_fetch_valid;
    if (model_ok) begin
      head_id       = (enq_total - exp_q.size()) % D;
      x_enq_ready   = (exp_q.size() < D) && !bus.flush_i;
      x_fetch_valid = (exp_q.size() > n_fetched) && !bus.flush_i;
      check("enq_ready",   64'(bus.enq_ready_o),   64'(x_enq_ready));
      check("fetch_valid", 64'(bus.fetch_valid_o), 64'(x_fetch_valid));
      check("count",       64'(bus.count_o),       64'(exp_q.size()));
      check("full",        64'(bus.full_o),        64'(exp_q.size() == D));
      check("empty",       64'(bus.empty_o),       64'(exp_q.size() == 0));
      check("epoch",       64'(bus.fetch_epoch_o), 64'(m_epoch));
      if (x_fetch_valid) begin
        e = exp_q[n_fetched];
        check("fetch_pc",     64'(bus.fetch_pc_o),              64'(e[98:67]));
        check("fetch_npc",    64'(bus.fetch_npc_o),             64'(e[66:35]));
        check("fetch_tgt",    64'(bus.fetch_pred_target_o),     64'(e[34:3]));
        check("fetch_slot_v", 64'(bus.fetch_pred_slot_valid_o), 64'(e[2]));
        check("fetch_slot_i", 64'(bus.fetch_pred_slot_idx_o),   64'(e[1:0]));
        check("fetch_id",     64'(bus.fetch_ftq_id_o),          64'((head_id + n_fetched) % D));
      end
      rid = int'(bus.rd_ftq_id_i);
      if (written[rid]) begin
        check("rd_pc",  64'(bus.rd_pc_o),  64'(m_rd_pc[rid]));
        check("rd_npc", 64'(bus.rd_npc_o), 64'(m_rd_npc[rid]));
      end
    end
    if (rst) begin
      exp_q.delete();
      n_fetched = 0;
      enq_total = 0;
      m_epoch   = 0;
      model_ok  = 1;
    end else if (model_ok) begin
      head_id = (enq_total - exp_q.size()) % D;
      if (bus.flush_i) begin
        exp_q.delete();
        n_fetched = 0;
        m_epoch = (m_epoch + 1) % (1 << EW_E);
      end else begin
        x_fetch_valid = exp_q.size() > n_fetched;
        d = (int'(bus.commit_ftq_id_i) - head_id + D) % D;
        if (bus.commit_valid_i && d < n_fetched) begin
          for (int k = 0; k <= d; k++) void'(exp_q.pop_front());
          n_fetched -= d + 1;
        end
        if (x_fetch_valid && bus.fetch_ready_i) n_fetched++;
        if (bus.enq_valid_i && x_enq_ready) begin
          exp_q.push_back({bus.enq_pc_i, bus.enq_npc_i, bus.enq_pred_target_i,
                           bus.enq_pred_slot_valid_i, bus.enq_pred_slot_idx_i});
          written[enq_total % D]  = 1;
          m_rd_pc[enq_total % D]  = bus.enq_pc_i;
          m_rd_npc[enq_total % D] = bus.enq_npc_i;
          enq_total++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.enq_valid_i = 0;
    bus.enq_pc_i = '0;
    bus.enq_npc_i = '0;
    bus.enq_pred_slot_valid_i = 0;
    bus.enq_pred_slot_idx_i = '0;
    bus.enq_pred_target_i = '0;
    bus.fetch_ready_i = 0;
    bus.commit_valid_i = 0;
    bus.commit_ftq_id_i = '0;
    bus.rd_ftq_id_i = '0;
    bus.flush_i = 0;
  endtask

  task automatic set_enq(input logic [PLEN-1:0] pc);
    bus.enq_valid_i = 1;
    bus.enq_pc_i = pc;
    bus.enq_npc_i = pc + 32'd16;
    bus.enq_pred_target_i = pc + 32'h100;
    bus.enq_pred_slot_valid_i = pc[4];
    bus.enq_pred_slot_idx_i = pc[3:2] ^ 2'd1;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic fill8(input logic [PLEN-1:0] base);
    for (int k = 0; k < 8; k++) begin
      set_enq(base + 32'(16*k));
      tick();
    end
    bus.enq_valid_i = 0;
  endtask

  int          ids[$];
  logic [31:0] pcs[$];

  initial begin
    int k_enq, max_cnt, last_id;
    bit got;
    clear_inputs();
    do_reset();

    // Reset values.
    @(negedge clk);
    check("rst_count",       64'(bus.count_o), 64'd0);
    check("rst_empty",       64'(bus.empty_o), 64'd1);
    check("rst_full",        64'(bus.full_o), 64'd0);
    check("rst_fetch_valid", 64'(bus.fetch_valid_o), 64'd0);
    check("rst_enq_ready",   64'(bus.enq_ready_o), 64'd1);
    check("rst_epoch",       64'(bus.fetch_epoch_o), 64'd0);

    // Fill with IFU stalled, then random read of id 3.
    tick();
    fill8(32'h8000_0000);
    bus.rd_ftq_id_i = 3;
    @(negedge clk);
    check("fill_full",      64'(bus.full_o), 64'd1);
    check("fill_enq_ready", 64'(bus.enq_ready_o), 64'd0);
    check("fill_fetch_id",  64'(bus.fetch_ftq_id_o), 64'd0);
    check("fill_fetch_pc",  64'(bus.fetch_pc_o), 64'h8000_0000);
    check("rd_npc_id3",     64'(bus.rd_npc_o), 64'h8000_0040);

    // Fetch 3, commit id 1, then an out-of-range commit, then commit id 2.
    tick();
    bus.fetch_ready_i = 1;
    tick(); tick(); tick();
    bus.fetch_ready_i = 0;
    bus.commit_valid_i = 1;
    bus.commit_ftq_id_i = 1;
    tick();
    bus.commit_valid_i = 0;
    @(negedge clk);
    check("commit1_count", 64'(bus.count_o), 64'd6);
    tick();
    bus.commit_valid_i = 1;
    bus.commit_ftq_id_i = 5;
    tick();
    bus.commit_valid_i = 0;
    @(negedge clk);
    check("commit5_ignored", 64'(bus.count_o), 64'd6);
    tick();
    bus.commit_valid_i = 1;
    bus.commit_ftq_id_i = 2;
    tick();
    bus.commit_valid_i = 0;
    @(negedge clk);
    check("commit2_count", 64'(bus.count_o), 64'd5);

    // Full queue: commit and enqueue in the same cycle.
    do_reset();
    fill8(32'hB000_0000);
    bus.fetch_ready_i = 1;
    tick();
    bus.fetch_ready_i = 0;
    bus.commit_valid_i = 1;
    bus.commit_ftq_id_i = 0;
    set_enq(32'hA000_0000);
    @(negedge clk);
    check("full_commit_enq_ready", 64'(bus.enq_ready_o), 64'd0);
    tick();
    bus.commit_valid_i = 0;
    @(negedge clk);
    check("after_commit_enq_ready", 64'(bus.enq_ready_o), 64'd1);
    check("after_commit_count",     64'(bus.count_o), 64'd7);
    tick();
    bus.enq_valid_i = 0;
    bus.rd_ftq_id_i = 0;
    @(negedge clk);
    check("rewrite_rd_pc", 64'(bus.rd_pc_o), 64'hA000_0000);
    check("rewrite_count", 64'(bus.count_o), 64'd8);

    // Flush with 5 entries and a same-cycle enqueue, then 7 more flushes.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_enq(32'h9000_0000 + 32'(16*k));
      tick();
    end
    set_enq(32'hDEAD_0000);
    bus.flush_i = 1;
    @(negedge clk);
    check("flush_cycle_fetch_valid", 64'(bus.fetch_valid_o), 64'd0);
    check("flush_cycle_enq_ready",   64'(bus.enq_ready_o), 64'd0);
    tick();
    bus.flush_i = 0;
    bus.enq_valid_i = 0;
    @(negedge clk);
    check("flush_empty",       64'(bus.empty_o), 64'd1);
    check("flush_count",       64'(bus.count_o), 64'd0);
    check("flush_fetch_valid", 64'(bus.fetch_valid_o), 64'd0);
    check("flush_epoch",       64'(bus.fetch_epoch_o), 64'd1);
    tick();
    bus.flush_i = 1;
    for (int k = 0; k < 7; k++) tick();
    bus.flush_i = 0;
    @(negedge clk);
    check("epoch_wrap", 64'(bus.fetch_epoch_o), 64'd0);

    // Wrap-around stream with immediate fetch and commit.
    do_reset();
    bus.fetch_ready_i = 1;
    k_enq = 0; max_cnt = 0; got = 0; last_id = 0;
    ids.delete();
    pcs.delete();
    for (int cyc = 0; cyc < 80 && ids.size() < 20; cyc++) begin
      if (k_enq < 20) set_enq(32'hC000_0000 + 32'(16*k_enq));
      else bus.enq_valid_i = 0;
      @(negedge clk);
      if (int'(bus.count_o) > max_cnt) max_cnt = int'(bus.count_o);
      got = bus.fetch_valid_o;
      if (got) begin
        last_id = int'(bus.fetch_ftq_id_o);
        ids.push_back(last_id);
        pcs.push_back(bus.fetch_pc_o);
      end
      if (bus.enq_valid_i && bus.enq_ready_o) k_enq++;
      tick();
      bus.commit_valid_i = got;
      bus.commit_ftq_id_i = 3'(last_id);
    end
    clear_inputs();
    check("wrap_fetch_count", 64'(ids.size()), 64'd20);
    check("wrap_max_count",   64'(max_cnt <= 8), 64'd1);
    for (int i = 0; i < ids.size(); i++) begin
      check("wrap_id", 64'(ids[i]), 64'(i % 8));
      check("wrap_pc", 64'(pcs[i]), 64'(32'hC000_0000 + 32'(16*i)));
    end

    // Randomised traffic checked by the model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) != 0) set_enq($urandom);
      else bus.enq_valid_i = 0;
      bus.fetch_ready_i   = ($urandom_range(0, 2) != 0);
      bus.commit_valid_i  = ($urandom_range(0, 1) != 0);
      bus.commit_ftq_id_i = 3'($urandom_range(0, D-1));
      bus.rd_ftq_id_i     = 3'($urandom_range(0, D-1));
      bus.flush_i         = ($urandom_range(0, 39) == 0);
      rst                 = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
